// File: rtl/aes_link_pkg.sv
// Constants and state type shared by both ends of the 9-bit AES result link
// (shakehand + tx[7:0]).
package aes_link_pkg;

  localparam int LINK_NUM_BYTES = 16;
  localparam int LINK_WIDTH     = 9;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2
  } link_state_e;

endpackage

// File: rtl/aes_result_tx_if.sv
// Result handshake from the AES core plus the outgoing link and status.
// The transmitter uses the slave modport; the core/link side uses master.
interface aes_result_tx_if;

  logic [127:0] in_data;
  logic         in_valid;
  logic         in_ready;
  logic         shakehand;
  logic [7:0]   tx;
  logic         busy;
  logic [31:0]  frames_sent;

  modport slave (
    input  in_data, in_valid,
    output in_ready, shakehand, tx, busy, frames_sent
  );

  modport master (
    output in_data, in_valid,
    input  in_ready, shakehand, tx, busy, frames_sent
  );

endinterface

// File: rtl/aes_result_tx.sv
// Serialises each 128-bit AES result into 16 bytes on the shakehand/tx link,
// with a one-deep pending buffer so the core can hand over the next result early.
//   state | meaning
//   IDLE  | waiting; loads the pending frame and emits byte 0 when one is held
//   SEND  | holding byte byte_idx on tx for BYTE_CYCLES cycles
//   GAP   | inter-frame idle for GAP_CYCLES cycles, tx and shakehand frozen
module aes_result_tx
  import aes_link_pkg::*;
#(
  parameter int BYTE_CYCLES = 4,
  parameter int GAP_CYCLES  = 2
) (
  input  logic           clk,
  input  logic           rst,
  aes_result_tx_if.slave link
);

  localparam int NUM_BYTES = LINK_NUM_BYTES;
  localparam int IW        = $clog2(NUM_BYTES);
  localparam int CNT_MAX   = (BYTE_CYCLES > GAP_CYCLES) ? BYTE_CYCLES : GAP_CYCLES;
  localparam int CW        = $clog2(CNT_MAX + 1);

  localparam logic [CW-1:0] BYTE_LAST = CW'(BYTE_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_CYCLES - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_BYTES - 1);

  link_state_e   state_q, state_d;
  logic [127:0]  pend_data_q, pend_data_d;
  logic          pend_valid_q, pend_valid_d;
  logic [127:0]  shift_q, shift_d;
  logic [7:0]    tx_q, tx_d;
  logic          sh_q, sh_d;
  logic [IW-1:0] byte_idx_q, byte_idx_d;
  logic [CW-1:0] hold_q, hold_d;
  logic [31:0]   frames_q, frames_d;
  logic          accept;

  // in_ready is !pend_valid_q, so an accept and an IDLE load never share an edge
  assign accept = link.in_valid && !pend_valid_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      pend_data_q  <= '0;
      pend_valid_q <= 1'b0;
      shift_q      <= '0;
      tx_q         <= 8'h00;
      sh_q         <= 1'b0;
      byte_idx_q   <= '0;
      hold_q       <= '0;
      frames_q     <= '0;
    end else begin
      state_q      <= state_d;
      pend_data_q  <= pend_data_d;
      pend_valid_q <= pend_valid_d;
      shift_q      <= shift_d;
      tx_q         <= tx_d;
      sh_q         <= sh_d;
      byte_idx_q   <= byte_idx_d;
      hold_q       <= hold_d;
      frames_q     <= frames_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    pend_data_d  = pend_data_q;
    pend_valid_d = pend_valid_q;
    shift_d      = shift_q;
    tx_d         = tx_q;
    sh_d         = sh_q;
    byte_idx_d   = byte_idx_q;
    hold_d       = hold_q;
    frames_d     = frames_q;

    if (accept) begin
      pend_data_d  = link.in_data;
      pend_valid_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (pend_valid_q) begin
          tx_d         = pend_data_q[127:120];
          shift_d      = pend_data_q << 8;
          sh_d         = ~sh_q;
          byte_idx_d   = '0;
          hold_d       = '0;
          pend_valid_d = 1'b0;
          state_d      = ST_SEND;
        end
      end
      ST_SEND: begin
        if (hold_q == BYTE_LAST) begin
          hold_d = '0;
          if (byte_idx_q != IDX_LAST) begin
            tx_d       = shift_q[127:120];
            shift_d    = shift_q << 8;
            sh_d       = ~sh_q;
            byte_idx_d = byte_idx_q + 1'b1;
          end else begin
            frames_d = frames_q + 32'd1;
            state_d  = (GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;
          end
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      ST_GAP: begin
        if (hold_q == GAP_LAST) begin
          hold_d  = '0;
          state_d = ST_IDLE;
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign link.in_ready    = !pend_valid_q;
  assign link.shakehand   = sh_q;
  assign link.tx          = tx_q;
  assign link.busy        = (state_q != ST_IDLE) || pend_valid_q;
  assign link.frames_sent = frames_q;

endmodule

// File: tb/tb_aes_result_tx.sv
// Bench for aes_result_tx: a link monitor compares every shakehand toggle with a
// byte queue built from the frames the bench hands over, plus directed timing checks.
module tb_aes_result_tx;
  import aes_link_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  aes_result_tx_if u_if0 ();
  aes_result_tx_if u_if1 ();

  aes_result_tx #(.BYTE_CYCLES(4), .GAP_CYCLES(2)) u_dut0 (.clk(clk), .rst(rst), .link(u_if0));
  aes_result_tx #(.BYTE_CYCLES(1), .GAP_CYCLES(0)) u_dut1 (.clk(clk), .rst(rst), .link(u_if1));

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] q0[$];
  logic [7:0] q1[$];
  int tog0[$];
  int tog1[$];
  logic psh0 = 1'b0, psh1 = 1'b0;
  logic [7:0] ptx0 = 8'h00, ptx1 = 8'h00;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_frame(input int s, input logic [127:0] d);
    for (int k = 0; k < LINK_NUM_BYTES; k++) begin
      if (s == 1) q1.push_back(d[127-8*k -: 8]);
      else        q0.push_back(d[127-8*k -: 8]);
    end
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic idle_at(input int s, input logic [31:0] target);
    if (s == 1) return (u_if1.frames_sent == target) && !u_if1.busy;
    return (u_if0.frames_sent == target) && !u_if0.busy;
  endfunction

  task automatic wait_done(input int s, input logic [31:0] target, input string tag);
    int n = 0;
    while (!idle_at(s, target) && n < 400) begin
      @(negedge clk);
      n++;
    end
    check(tag, idle_at(s, target), 1'b1);
  endtask

  // link monitors: each toggle must carry the next expected byte; tx never moves alone
  always @(posedge clk) begin
    #1;
    if (rst) begin
      psh0 = 1'b0; ptx0 = 8'h00;
    end else begin
      if (u_if0.shakehand !== psh0) begin
        tog0.push_back(cyc);
        check("link0_byte_pending", q0.size() > 0, 1'b1);
        if (q0.size() > 0) check("link0_byte", u_if0.tx, q0.pop_front());
      end else if (u_if0.tx !== ptx0) begin
        check("link0_tx_stable", u_if0.tx, ptx0);
      end
      psh0 = u_if0.shakehand; ptx0 = u_if0.tx;
    end
  end

  always @(posedge clk) begin
    #1;
    if (rst) begin
      psh1 = 1'b0; ptx1 = 8'h00;
    end else begin
      if (u_if1.shakehand !== psh1) begin
        tog1.push_back(cyc);
        check("link1_byte_pending", q1.size() > 0, 1'b1);
        if (q1.size() > 0) check("link1_byte", u_if1.tx, q1.pop_front());
      end else if (u_if1.tx !== ptx1) begin
        check("link1_tx_stable", u_if1.tx, ptx1);
      end
      psh1 = u_if1.shakehand; ptx1 = u_if1.tx;
    end
  end

  initial begin
    int base;
    int n;
    logic ok;
    logic [127:0] a, b;

    u_if0.in_data = '0; u_if0.in_valid = 1'b0;
    u_if1.in_data = '0; u_if1.in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk); @(negedge clk);
    check("rst_tx", u_if0.tx, 8'h00);
    check("rst_shakehand", u_if0.shakehand, 1'b0);
    check("rst_in_ready", u_if0.in_ready, 1'b1);
    check("rst_busy", u_if0.busy, 1'b0);
    check("rst_frames", u_if0.frames_sent, 32'd0);
    rst = 1'b0;

    // single frame with the reference pattern
    @(negedge clk);
    tog0.delete();
    a = 128'h00112233445566778899AABBCCDDEEFF;
    u_if0.in_data = a; u_if0.in_valid = 1'b1; push_frame(0, a);
    base = cyc;
    @(negedge clk);
    u_if0.in_valid = 1'b0;
    check("t1_ready_after_accept", u_if0.in_ready, 1'b0);
    check("t1_busy_pending", u_if0.busy, 1'b1);
    @(negedge clk);
    check("t1_first_byte", u_if0.tx, 8'h00);
    check("t1_first_toggle", tog0.size(), 1);
    check("t1_ready_after_load", u_if0.in_ready, 1'b1);
    n = 0;
    while (u_if0.frames_sent != 32'd1 && n < 200) begin @(negedge clk); n++; end
    check("t1_frame_done_cycle", cyc, base + 66);
    check("t1_toggle_count", tog0.size(), 16);
    check("t1_last_toggle_cycle", (tog0.size() == 16) ? tog0[15] : -1, base + 62);
    check("t1_last_byte", u_if0.tx, 8'hFF);
    check("t1_parity_restored", u_if0.shakehand, 1'b0);
    wait_done(0, 32'd1, "t1_idle");
    check("t1_queue_drained", q0.size(), 0);

    // back-to-back frames with in_valid held high
    @(negedge clk);
    tog0.delete();
    a = 128'h0102030405060708090A0B0C0D0E0F10;
    b = 128'hF0E0D0C0B0A090807060504030201000;
    u_if0.in_data = a; u_if0.in_valid = 1'b1; push_frame(0, a);
    @(negedge clk);
    u_if0.in_data = b; push_frame(0, b);
    check("t2_ready_low_a", u_if0.in_ready, 1'b0);
    @(negedge clk);
    check("t2_ready_high_after_load", u_if0.in_ready, 1'b1);
    @(negedge clk);
    u_if0.in_valid = 1'b0;
    check("t2_b_accepted", u_if0.in_ready, 1'b0);
    ok = 1'b1; n = 0;
    while (tog0.size() < 17 && n < 100) begin
      if (u_if0.in_ready !== 1'b0) ok = 1'b0;
      @(negedge clk); n++;
    end
    check("t2_ready_held_low", ok, 1'b1);
    check("t2_ready_after_b_load", u_if0.in_ready, 1'b1);
    check("t2_b_first_byte_delay", (tog0.size() >= 17) ? tog0[16] - tog0[0] : -1, 67);
    check("t2_b_first_byte", u_if0.tx, 8'hF0);
    wait_done(0, 32'd3, "t2_idle");
    check("t2_queue_drained", q0.size(), 0);

    // backpressure: one sending, one pending, a third offered for 40 cycles
    @(negedge clk);
    a = rnd128(); b = rnd128();
    u_if0.in_data = a; u_if0.in_valid = 1'b1; push_frame(0, a);
    @(negedge clk);
    u_if0.in_data = b; push_frame(0, b);
    @(negedge clk);
    @(negedge clk);
    u_if0.in_data = rnd128();
    ok = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (u_if0.in_ready !== 1'b0) ok = 1'b0;
      @(negedge clk);
    end
    u_if0.in_valid = 1'b0;
    check("t3_ready_held_low", ok, 1'b1);
    wait_done(0, 32'd5, "t3_idle");
    check("t3_queue_drained", q0.size(), 0);
    check("t3_ready_final", u_if0.in_ready, 1'b1);

    // one byte per cycle, no gap
    @(negedge clk);
    tog1.delete();
    a = {16{8'hA5}}; b = rnd128();
    u_if1.in_data = a; u_if1.in_valid = 1'b1; push_frame(1, a);
    @(negedge clk);
    u_if1.in_data = b; push_frame(1, b);
    @(negedge clk);
    @(negedge clk);
    u_if1.in_valid = 1'b0;
    check("t4_b_accepted", u_if1.in_ready, 1'b0);
    wait_done(1, 32'd2, "t4_idle");
    check("t4_toggle_count", tog1.size(), 32);
    ok = (tog1.size() == 32);
    for (int k = 1; k < 16 && ok; k++) if (tog1[k] - tog1[k-1] != 1) ok = 1'b0;
    check("t4_toggle_every_cycle", ok, 1'b1);
    check("t4_frame_period", (tog1.size() >= 17) ? tog1[16] - tog1[0] : -1, 17);
    check("t4_queue_drained", q1.size(), 0);

    // reset mid-frame drops both the in-flight and the pending frame
    @(negedge clk);
    tog0.delete();
    a = rnd128(); b = rnd128();
    u_if0.in_data = a; u_if0.in_valid = 1'b1; push_frame(0, a);
    @(negedge clk);
    u_if0.in_data = b; push_frame(0, b);
    @(negedge clk);
    @(negedge clk);
    u_if0.in_valid = 1'b0;
    n = 0;
    while (tog0.size() < 7 && n < 100) begin @(negedge clk); n++; end
    check("t5_seven_bytes", tog0.size(), 7);
    @(posedge clk);
    #3;
    rst = 1'b1;
    q0.delete();
    #1;
    check("t5_rst_tx", u_if0.tx, 8'h00);
    check("t5_rst_shakehand", u_if0.shakehand, 1'b0);
    check("t5_rst_frames", u_if0.frames_sent, 32'd0);
    check("t5_rst_ready", u_if0.in_ready, 1'b1);
    check("t5_rst_busy", u_if0.busy, 1'b0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    tog0.delete();
    @(negedge clk);
    a = {32'hDEADBEEF, $urandom, $urandom, $urandom};
    u_if0.in_data = a; u_if0.in_valid = 1'b1; push_frame(0, a);
    @(negedge clk);
    u_if0.in_valid = 1'b0;
    wait_done(0, 32'd1, "t5_post_reset_frame");
    check("t5_toggle_count", tog0.size(), 16);
    check("t5_queue_drained", q0.size(), 0);

    // frames_sent wraps to zero
    @(negedge clk);
    a = rnd128();
    u_if0.in_data = a; u_if0.in_valid = 1'b1; push_frame(0, a);
    @(negedge clk);
    u_if0.in_valid = 1'b0;
    repeat (8) @(negedge clk);
    force u_dut0.frames_q = 32'hFFFFFFFF;
    @(negedge clk);
    release u_dut0.frames_q;
    check("t6_forced_value", u_if0.frames_sent, 32'hFFFFFFFF);
    wait_done(0, 32'd0, "t6_wrap");
    check("t6_queue_drained", q0.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
